// File: rtl/mcu_spi_packetizer.sv
// ---------------------------------------------------------------------------
// mcu_spi_packetizer
//
// SPI slave (mode 0) that streams staged BNO085 quaternion and gyro samples
// for NUM_SENSORS sensors to an MCU acting as SPI master. Everything runs in
// the clk domain: SCK, CS_N and SDI are oversampled through SYNC_STAGES-deep
// synchronizers and their edges are detected one clock later.
//
// Packet (PACKET_BYTES = 3 + 15*NUM_SENSORS), sent MSB first:
//   HEADER, SEQ,
//   per sensor: qw qx qy qz gx gy gz (MSB, LSB each), FLAGS
//   XOR of all preceding bytes
// FLAGS: bit0 quat fresh, bit1 gyro fresh, bit2 overrun, bits7:3 zero.
//
// Ports:
//   clk         system clock, at least 8x the SCK frequency
//   rst_n       synchronous active-low reset
//   sck, cs_n   SPI clock / chip select from the MCU (asynchronous)
//   sdi         MOSI, synchronized but otherwise unused
//   sdo         MISO, registered
//   done        unread sensor data is staged
//   busy        a transaction is in progress
//   quat_valid  per-sensor strobe for quat_w/x/y/z (sensor i at [16i+15:16i])
//   gyro_valid  per-sensor strobe for gyro_x/y/z   (same packing)
// ---------------------------------------------------------------------------
module mcu_spi_packetizer #(
    parameter int         NUM_SENSORS = 2,
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sck,
    input  logic                      cs_n,
    input  logic                      sdi,
    output logic                      sdo,
    output logic                      done,
    output logic                      busy,
    input  logic [NUM_SENSORS-1:0]    quat_valid,
    input  logic [16*NUM_SENSORS-1:0] quat_w,
    input  logic [16*NUM_SENSORS-1:0] quat_x,
    input  logic [16*NUM_SENSORS-1:0] quat_y,
    input  logic [16*NUM_SENSORS-1:0] quat_z,
    input  logic [NUM_SENSORS-1:0]    gyro_valid,
    input  logic [16*NUM_SENSORS-1:0] gyro_x,
    input  logic [16*NUM_SENSORS-1:0] gyro_y,
    input  logic [16*NUM_SENSORS-1:0] gyro_z
);

    localparam int PACKET_BYTES = 3 + 15 * NUM_SENSORS;
    localparam int BODY_BYTES   = PACKET_BYTES - 1;
    localparam int PACKET_BITS  = 8 * PACKET_BYTES;
    localparam int FIELDS       = 7;
    localparam int CNT_W        = $clog2(PACKET_BITS + 1);

    localparam logic [CNT_W-1:0] LAST_BIT_IDX = CNT_W'(PACKET_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    // Transmit FSM: IDLE waits for CS_N fall, SHIFT sends the packet,
    // TAIL holds sdo low after the last bit until CS_N rises.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;

    // XOR of every body byte; the result closes the packet.
    function automatic logic [7:0] xor_checksum(input logic [7:0] data [BODY_BYTES]);
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < BODY_BYTES; j++) begin
            acc = acc ^ data[j];
        end
        return acc;
    endfunction

    // ---------------------------------------------------------------------
    // Synchronizers and edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sdi_sync_r;
    logic                   sck_prev_r;
    logic                   cs_prev_r;
    logic                   sck_s;
    logic                   cs_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic                   sdi_unused_s;

    // Oversample the SPI pins; reset parks them at the idle bus state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r  <= {SYNC_STAGES{1'b1}};
            sdi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_prev_r <= 1'b0;
            cs_prev_r  <= 1'b1;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
            sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
            sck_prev_r <= sck_sync_r[SYNC_STAGES-1];
            cs_prev_r  <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sck_s        = sck_sync_r[SYNC_STAGES-1];
    assign cs_s         = cs_sync_r[SYNC_STAGES-1];
    assign sdi_unused_s = sdi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s   = sck_s & ~sck_prev_r;
    assign sck_fall_s   = ~sck_s & sck_prev_r;
    assign cs_fall_s    = ~cs_s & cs_prev_r;
    assign cs_rise_s    = cs_s & ~cs_prev_r;

    // ---------------------------------------------------------------------
    // Staging registers and freshness flags
    // ---------------------------------------------------------------------
    logic [1:0]             state_r;
    logic                   snap_s;
    logic [15:0]            stage_r [NUM_SENSORS][FIELDS];
    logic [NUM_SENSORS-1:0] qf_r;
    logic [NUM_SENSORS-1:0] gf_r;
    logic [NUM_SENSORS-1:0] ov_r;
    logic [NUM_SENSORS-1:0] qf_base_s;
    logic [NUM_SENSORS-1:0] gf_base_s;
    logic [NUM_SENSORS-1:0] ov_base_s;
    logic [NUM_SENSORS-1:0] qf_next_s;
    logic [NUM_SENSORS-1:0] gf_next_s;
    logic [NUM_SENSORS-1:0] ov_next_s;
    logic                   done_r;

    assign snap_s = cs_fall_s & (state_r == ST_IDLE);

    // Next flag state. On a snapshot the current flags travel with the packet,
    // so a strobe in that same cycle is judged against cleared flags and
    // therefore never reports overrun for the next packet.
    always_comb begin
        qf_base_s = qf_r;
        gf_base_s = gf_r;
        ov_base_s = ov_r;
        if (snap_s) begin
            qf_base_s = {NUM_SENSORS{1'b0}};
            gf_base_s = {NUM_SENSORS{1'b0}};
            ov_base_s = {NUM_SENSORS{1'b0}};
        end else begin
            qf_base_s = qf_r;
            gf_base_s = gf_r;
            ov_base_s = ov_r;
        end
        qf_next_s = qf_base_s | quat_valid;
        gf_next_s = gf_base_s | gyro_valid;
        ov_next_s = ov_base_s | (quat_valid & qf_base_s) | (gyro_valid & gf_base_s);
    end

    // Latch strobed sensor fields and update flags / done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                for (int f = 0; f < FIELDS; f++) begin
                    stage_r[i][f] <= 16'h0000;
                end
            end
            qf_r   <= {NUM_SENSORS{1'b0}};
            gf_r   <= {NUM_SENSORS{1'b0}};
            ov_r   <= {NUM_SENSORS{1'b0}};
            done_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (quat_valid[i]) begin
                    stage_r[i][0] <= quat_w[16*i +: 16];
                    stage_r[i][1] <= quat_x[16*i +: 16];
                    stage_r[i][2] <= quat_y[16*i +: 16];
                    stage_r[i][3] <= quat_z[16*i +: 16];
                end
                if (gyro_valid[i]) begin
                    stage_r[i][4] <= gyro_x[16*i +: 16];
                    stage_r[i][5] <= gyro_y[16*i +: 16];
                    stage_r[i][6] <= gyro_z[16*i +: 16];
                end
            end
            qf_r   <= qf_next_s;
            gf_r   <= gf_next_s;
            ov_r   <= ov_next_s;
            done_r <= |(qf_next_s | gf_next_s);
        end
    end

    // ---------------------------------------------------------------------
    // Packet assembly (combinational view of staging, captured on snapshot)
    // ---------------------------------------------------------------------
    logic [7:0]             seq_r;
    logic [7:0]             body_s [BODY_BYTES];
    logic [7:0]             chk_s;
    logic [PACKET_BITS-1:0] packet_s;

    // Lay out header, sequence number, sensor fields and flags in byte order.
    always_comb begin
        for (int j = 0; j < BODY_BYTES; j++) begin
            body_s[j] = 8'h00;
        end
        body_s[0] = HEADER;
        body_s[1] = seq_r;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            for (int f = 0; f < FIELDS; f++) begin
                body_s[2 + 15*i + 2*f]     = stage_r[i][f][15:8];
                body_s[2 + 15*i + 2*f + 1] = stage_r[i][f][7:0];
            end
            body_s[2 + 15*i + 14] = {5'b00000, ov_r[i], gf_r[i], qf_r[i]};
        end
    end

    assign chk_s = xor_checksum(body_s);

    // Flatten the packet with byte 0 in the top bits so it shifts out MSB first.
    always_comb begin
        packet_s = {PACKET_BITS{1'b0}};
        for (int j = 0; j < BODY_BYTES; j++) begin
            packet_s[PACKET_BITS-1-8*j -: 8] = body_s[j];
        end
        packet_s[7:0] = chk_s;
    end

    // ---------------------------------------------------------------------
    // Transmit path
    // ---------------------------------------------------------------------
    logic [PACKET_BITS-2:0] tx_r;      // bits still to send after the one on sdo
    logic [CNT_W-1:0]       bit_cnt_r; // SCK rising edges seen this transaction
    logic                   sdo_r;
    logic                   busy_r;

    // Snapshot on CS_N fall, shift on SCK falls, abort on CS_N rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tx_r      <= {(PACKET_BITS-1){1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            sdo_r     <= 1'b0;
            busy_r    <= 1'b0;
            seq_r     <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (snap_s) begin
                        tx_r      <= packet_s[PACKET_BITS-2:0];
                        sdo_r     <= packet_s[PACKET_BITS-1];
                        seq_r     <= seq_r + 8'd1;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        tx_r      <= {(PACKET_BITS-1){1'b0}};
                        bit_cnt_r <= {CNT_W{1'b0}};
                        sdo_r     <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        if (sck_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            if (bit_cnt_r == LAST_BIT_IDX) begin
                                state_r <= ST_TAIL;
                            end
                        end
                        if (sck_fall_s) begin
                            sdo_r <= tx_r[PACKET_BITS-2];
                            tx_r  <= {tx_r[PACKET_BITS-3:0], 1'b0};
                        end
                    end
                end
                ST_TAIL: begin
                    if (cs_rise_s) begin
                        tx_r      <= {(PACKET_BITS-1){1'b0}};
                        bit_cnt_r <= {CNT_W{1'b0}};
                        sdo_r     <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (sck_fall_s) begin
                        sdo_r <= 1'b0;
                    end
                end
                default: begin
                    tx_r      <= {(PACKET_BITS-1){1'b0}};
                    bit_cnt_r <= {CNT_W{1'b0}};
                    sdo_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdo  = sdo_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_mcu_spi_packetizer.sv
// ---------------------------------------------------------------------------
// tb_mcu_spi_packetizer
//
// Self-checking bench for mcu_spi_packetizer with two sensors. A behavioural
// model of the staging registers builds the expected packet whenever CS_N is
// driven low and pushes it on a queue; the bytes shifted out on sdo are
// popped and compared. A table of strobe vectors drives the main flow, and
// hand-written sequences cover snapshot-cycle strobes, abort, reset in the
// middle of a transaction and the SEQ wrap.
// ---------------------------------------------------------------------------
module tb_mcu_spi_packetizer;

    localparam int NS  = 2;
    localparam int PB  = 3 + 15 * NS;
    localparam int RXB = PB + 1;          // packet plus one trailing byte
    localparam int RXW = 8 * RXB;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sck;
    logic              cs_n;
    logic              sdi;
    logic              sdo;
    logic              done;
    logic              busy;
    logic [NS-1:0]     quat_valid;
    logic [16*NS-1:0]  quat_w, quat_x, quat_y, quat_z;
    logic [NS-1:0]     gyro_valid;
    logic [16*NS-1:0]  gyro_x, gyro_y, gyro_z;

    always #5 clk = ~clk;

    mcu_spi_packetizer #(
        .NUM_SENSORS (NS),
        .HEADER      (8'hAA),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (sck),
        .cs_n       (cs_n),
        .sdi        (sdi),
        .sdo        (sdo),
        .done       (done),
        .busy       (busy),
        .quat_valid (quat_valid),
        .quat_w     (quat_w),
        .quat_x     (quat_x),
        .quat_y     (quat_y),
        .quat_z     (quat_z),
        .gyro_valid (gyro_valid),
        .gyro_x     (gyro_x),
        .gyro_y     (gyro_y),
        .gyro_z     (gyro_z)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model of staging, flags and sequence number.
    logic [15:0]    m_stage [NS][7];
    logic [NS-1:0]  m_qf, m_gf, m_ov;
    logic [7:0]     m_seq;
    logic [RXW-1:0] exp_q [$];
    logic [RXW-1:0] rx;

    typedef struct {
        logic [NS-1:0] qm;
        logic [NS-1:0] gm;
        logic [15:0]   a, b, c, d;
        logic          exp_done;
        bit            do_read;
        logic [7:0]    exp_f0, exp_f1, exp_seq;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_done();
        return |(m_qf | m_gf);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++)
            for (int f = 0; f < 7; f++)
                m_stage[i][f] = 16'h0000;
        m_qf  = '0;
        m_gf  = '0;
        m_ov  = '0;
        m_seq = 8'h00;
    endtask

    task automatic model_strobe(input logic [NS-1:0] qm, input logic [NS-1:0] gm,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        for (int i = 0; i < NS; i++) begin
            if (qm[i]) begin
                if (m_qf[i]) m_ov[i] = 1'b1;
                m_qf[i] = 1'b1;
                m_stage[i][0] = a; m_stage[i][1] = b;
                m_stage[i][2] = c; m_stage[i][3] = d;
            end
            if (gm[i]) begin
                if (m_gf[i]) m_ov[i] = 1'b1;
                m_gf[i] = 1'b1;
                m_stage[i][4] = a; m_stage[i][5] = b; m_stage[i][6] = c;
            end
        end
    endtask

    // Build the expected packet (byte j at bits [8j+7:8j]) and queue it.
    task automatic model_snapshot();
        logic [RXW-1:0] p;
        logic [7:0]     chk;
        int             base;
        p = '0;
        p[7:0]  = 8'hAA;
        p[15:8] = m_seq;
        for (int i = 0; i < NS; i++) begin
            base = 2 + 15 * i;
            for (int f = 0; f < 7; f++) begin
                p[8*(base+2*f)   +: 8] = m_stage[i][f][15:8];
                p[8*(base+2*f+1) +: 8] = m_stage[i][f][7:0];
            end
            p[8*(base+14) +: 8] = {5'b00000, m_ov[i], m_gf[i], m_qf[i]};
        end
        chk = 8'h00;
        for (int j = 0; j < PB - 1; j++) chk = chk ^ p[8*j +: 8];
        p[8*(PB-1) +: 8] = chk;
        exp_q.push_back(p);
        m_qf  = '0;
        m_gf  = '0;
        m_ov  = '0;
        m_seq = m_seq + 8'd1;
    endtask

    // One-cycle strobe; returns at the following negedge.
    task automatic drive_strobe(input logic [NS-1:0] qm, input logic [NS-1:0] gm,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        @(negedge clk);
        quat_w = {NS{a}}; quat_x = {NS{b}}; quat_y = {NS{c}}; quat_z = {NS{d}};
        gyro_x = {NS{a}}; gyro_y = {NS{b}}; gyro_z = {NS{c}};
        quat_valid = qm;
        gyro_valid = gm;
        model_strobe(qm, gm, a, b, c, d);
        @(negedge clk);
        quat_valid = '0;
        gyro_valid = '0;
    endtask

    // SPI master transaction; inj_g strobes gyro data in the snapshot cycle.
    task automatic xfer(input int nbits, input logic [NS-1:0] inj_g,
                        input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ic,
                        input bit release_cs, output logic [RXW-1:0] data);
        data = '0;
        @(negedge clk);
        cs_n = 1'b0;
        model_snapshot();
        repeat (2) @(negedge clk);
        gyro_x = {NS{ia}}; gyro_y = {NS{ib}}; gyro_z = {NS{ic}};
        gyro_valid = inj_g;
        model_strobe('0, inj_g, ia, ib, ic, 16'h0000);
        @(negedge clk);
        gyro_valid = '0;
        repeat (3) @(negedge clk);
        check("busy_after_cs_fall", busy, 1);
        check("done_after_snapshot", done, model_done());
        for (int b = 0; b < nbits; b++) begin
            data[8*(b/8) + 7 - (b%8)] = sdo;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (release_cs) begin
            cs_n = 1'b1;
            repeat (4) @(negedge clk);
            check("busy_after_cs_rise", busy, 0);
        end
    endtask

    task automatic compare_pkt(input int nbytes, input logic [RXW-1:0] data, input string tag);
        logic [RXW-1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_queue: got empty scoreboard, expected a packet", tag);
        end else begin
            e = exp_q.pop_front();
            for (int j = 0; j < nbytes; j++)
                check($sformatf("%s_byte%0d", tag, j), data[8*j +: 8], e[8*j +: 8]);
        end
    endtask

    task automatic full_read(input string tag, input logic [NS-1:0] inj_g,
                             input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ic);
        logic [7:0] x;
        xfer(8 * RXB, inj_g, ia, ib, ic, 1'b1, rx);
        compare_pkt(RXB, rx, tag);
        x = 8'h00;
        for (int j = 0; j < PB; j++) x = x ^ rx[8*j +: 8];
        check({tag, "_xor_all"}, x, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 2'b00, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00};
        vecs[1] = '{2'b10, 2'b00, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{2'b10, 2'b00, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b1, 1'b1, 8'h00, 8'h05, 8'h01};
        vecs[3] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 8'h02};
        vecs[4] = '{2'b00, 2'b11, 16'h8001, 16'h7FFF, 16'h0F0F, 16'h0000, 1'b1, 1'b1, 8'h02, 8'h02, 8'h03};
        vecs[5] = '{2'b11, 2'b01, 16'hFFFF, 16'h0000, 16'hABCD, 16'h1357, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{2'b00, 2'b01, 16'h0102, 16'h0304, 16'h0506, 16'h0000, 1'b1, 1'b1, 8'h07, 8'h01, 8'h04};

        rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
        quat_valid = '0; gyro_valid = '0;
        quat_w = '0; quat_x = '0; quat_y = '0; quat_z = '0;
        gyro_x = '0; gyro_y = '0; gyro_z = '0;
        model_reset();
        repeat (4) @(negedge clk);
        check("reset_sdo", sdo, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven strobes and reads.
        for (int v = 0; v < 7; v++) begin
            drive_strobe(vecs[v].qm, vecs[v].gm, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
            check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            if (vecs[v].do_read) begin
                full_read($sformatf("vec%0d", v), '0, 16'h0, 16'h0, 16'h0);
                check($sformatf("vec%0d_seq", v), rx[15:8], vecs[v].exp_seq);
                check($sformatf("vec%0d_flags0", v), rx[8*16 +: 8], vecs[v].exp_f0);
                check($sformatf("vec%0d_flags1", v), rx[8*31 +: 8], vecs[v].exp_f1);
                check($sformatf("vec%0d_done_after_read", v), done, 0);
            end
        end

        // Gyro strobe in the snapshot cycle goes to the next packet.
        drive_strobe(2'b01, 2'b00, 16'h0F00, 16'h0001, 16'h0002, 16'h0003);
        full_read("snapcyc", 2'b10, 16'h4444, 16'h5555, 16'h6666);
        check("snapcyc_flags1", rx[8*31 +: 8], 8'h00);
        check("snapcyc_done_kept", done, 1);
        full_read("snapnext", '0, 16'h0, 16'h0, 16'h0);
        check("snapnext_flags1", rx[8*31 +: 8], 8'h02);
        check("snapnext_done", done, 0);

        // SCK activity with CS_N high is ignored.
        for (int k = 0; k < 3; k++) begin
            sck = 1'b1; repeat (4) @(negedge clk);
            sck = 1'b0; repeat (4) @(negedge clk);
        end
        check("idle_sck_busy", busy, 0);
        check("idle_sck_sdo", sdo, 0);

        // Abort after 20 bits; the discarded flags are not restored.
        drive_strobe(2'b10, 2'b00, 16'h2468, 16'h1357, 16'hFACE, 16'hBEEF);
        xfer(20, '0, 16'h0, 16'h0, 16'h0, 1'b1, rx);
        compare_pkt(2, rx, "abort");
        full_read("after_abort", '0, 16'h0, 16'h0, 16'h0);
        check("after_abort_flags1", rx[8*31 +: 8], 8'h00);

        // Reset in the middle of a transaction.
        drive_strobe(2'b01, 2'b00, 16'h0F00, 16'h0000, 16'h0000, 16'h0000);
        xfer(20, '0, 16'h0, 16'h0, 16'h0, 1'b0, rx);
        compare_pkt(2, rx, "prereset");
        check("prereset_sdo", sdo, 1);
        check("prereset_done", done, 0);
        drive_strobe(2'b10, 2'b00, 16'h7777, 16'h0000, 16'h0000, 16'h0000);
        check("prereset_done_set", done, 1);
        @(negedge clk);
        rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0;
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_sdo", sdo, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        full_read("post_reset", '0, 16'h0, 16'h0, 16'h0);
        check("post_reset_seq", rx[15:8], 8'h00);
        check("post_reset_qw0", rx[8*2 +: 8], 8'h00);

        // SEQ 01..FF with short reads, then the wrap to 00 with a full packet.
        for (int k = 1; k < 256; k++) begin
            xfer(16, '0, 16'h0, 16'h0, 16'h0, 1'b1, rx);
            compare_pkt(2, rx, "seqrun");
            check("seqrun_seq", rx[15:8], k[7:0]);
        end
        full_read("seq_wrap", '0, 16'h0, 16'h0, 16'h0);
        check("seq_wrap_seq", rx[15:8], 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mcu_spi_packetizer.md
Name: mcu_spi_packetizer

Overview:
Parametrised next-generation FPGA-side SPI slave that streams raw BNO085 quaternion and gyro data for NUM_SENSORS sensors to the MCU (SPI master, mode 0).
- SCK, CS_N and SDI are oversampled in the clk domain; everything runs on a single clock.
- Incoming samples are latched into per-sensor staging registers.
- The staging registers are snapshotted atomically into a transmit buffer at the start of each transaction.
- Each packet adds a sequence number, per-sensor freshness/overrun flags and an XOR checksum.

Parameters:
NUM_SENSORS, 2, number of sensor channels (1..4)
HEADER, 8'hAA, first byte of every packet
SYNC_STAGES, 2, synchronizer depth on sck/cs_n/sdi (>=2)

Ports:
clk  input  1  FPGA system clock; must be >= 8x SCK frequency
rst_n  input  1  synchronous active-low reset
sck  input  1  SPI clock from MCU (async)
cs_n  input  1  SPI chip select from MCU, active low (async)
sdi  input  1  MOSI; synchronized, otherwise ignored
sdo  output  1  MISO to MCU
done  output  1  unread sensor data staged; MCU may start a transaction
busy  output  1  transaction in progress (cs_n low, synchronized)
quat_valid  input  NUM_SENSORS  per-sensor 1-cycle strobe, quaternion fields valid
quat_w, quat_x, quat_y, quat_z  input  16*NUM_SENSORS each  signed, sensor i at [16i+15:16i]
gyro_valid  input  NUM_SENSORS  per-sensor 1-cycle strobe, gyro fields valid
gyro_x, gyro_y, gyro_z  input  16*NUM_SENSORS each  signed, same packing

Behaviour:
- Packet layout, PACKET_BYTES = 3 + 15*NUM_SENSORS:
  - byte0 HEADER
  - byte1 SEQ
  - per sensor i, in order: qw,qx,qy,qz (MSB then LSB), gx,gy,gz (MSB then LSB), then FLAGS_i
  - last byte is the XOR of all preceding bytes
- FLAGS_i: bit0 quat fresh; bit1 gyro fresh; bit2 overrun (a second strobe of either kind arrived since the previous snapshot); bits7:3 = 0.
- Staging:
  - A quat_valid[i] or gyro_valid[i] strobe overwrites the corresponding staged fields.
  - The strobe sets the matching fresh bit. It also sets overrun if that fresh bit was already 1.
- done:
  - Rises 1 clk after any strobe.
  - Falls on snapshot unless a strobe arrives in the snapshot cycle.
- CS_N fall, detected after sync plus 1 clk edge detect, with a total latency of SYNC_STAGES+1 clk: snapshot.
  - Staging data, flags, SEQ and the computed checksum are copied into the tx buffer.
  - Fresh and overrun bits are cleared.
  - SEQ increments after the copy, wrapping 255->0.
  - The bit counter is cleared and busy is set.
- Strobes arriving in the snapshot cycle go to staging for the NEXT packet. Their fresh bits stay set and done stays/returns to 1.
- Transmit path:
  - sdo = bit7 of byte0 from the snapshot cycle.
  - On each detected SCK falling edge while busy, sdo advances to the next bit, MSB first.
  - The MCU samples on SCK rising. The first SCK rise must come >= SYNC_STAGES+3 clk after the CS_N fall.
  - The bit counter counts detected SCK rising edges. After 8*PACKET_BYTES bits, sdo is held 0 until CS_N rises.
- SCK edges while cs_n is high are ignored.
- CS_N rise mid-packet aborts the transfer:
  - busy clears and the bit counter clears.
  - The snapshotted packet is discarded and its flags are not restored.
  - The next transaction takes a new snapshot.
- A transaction with no fresh data is legal. The packet carries the last staged values with flags 0, and SEQ still increments.
- Reset, including mid-transaction:
  - sdo=0, done=0, busy=0, SEQ=0, bit counter 0.
  - All staging and tx registers 0; synchronizers are reset to idle (cs_n=1, sck=0).

Test Plan:
- Reset, NUM_SENSORS=2; strobe quat_valid=2'b01 with w=16'h1234, x=16'h5678, y=16'h9ABC, z=16'hDEF0 -> done=1 after 1 clk. A 33-byte read returns AA 00 12 34 56 78 9A BC DE F0 00*6 01, then sensor1 all 00 with FLAGS 00, then XOR checksum. done=0 after snapshot.
- Two quat strobes on sensor 1 before a read -> FLAGS_1 = 8'h05 and the second strobe's values are sent. The next read shows FLAGS_1 = 00 and SEQ = 01.
- gyro_valid strobe in exactly the snapshot cycle -> current packet FLAGS bit1=0. done remains 1; the following packet has bit1=1.
- Abort: raise CS_N after 20 bits -> busy=0. A new transaction returns a full packet with the next SEQ and correct checksum.
- 256 consecutive reads -> SEQ runs 00..FF and then returns 00. Every checksum matches the XOR of the preceding bytes.
- Assert rst_n=0 mid-transaction -> sdo=0, busy=0, done=0 next clk. The first post-reset packet has SEQ=00 and all data 0.
